buzzer_tone_detector: RTL

Receive-side counterpart of the piano's buzzer counter. It samples a square-wave tone line and measures its period in clock cycles. A measurement is reported only after two consecutive matching periods, and the block flags silence when edges stop. It sits between a tone source (buzzer output or external pin) and note-recognition or self-check logic in the Piano design.

---
 rtl/buzzer_tone_detector.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/buzzer_tone_detector.sv
// buzzer_tone_detector
// Measures the period of a square-wave tone line in clock cycles. A period is
// reported only after two consecutive samples agree within TOL. Silence is
// flagged when no qualified rising edge arrives for TIMEOUT cycles.
module buzzer_tone_detector #(
   parameter int CNT_W      = 20,
   parameter int TIMEOUT    = 200000,
   parameter int MIN_PERIOD = 4,
   parameter int TOL        = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tone_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             tone_new,
   output logic             silent
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   MIN_C     = (CNT_W+1)'(MIN_PERIOD);
   localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

   state_t           state;
   state_t           state_n;
   logic             s1;
   logic             s2;
   logic             s3;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cand;
   logic [CNT_W-1:0] cand_n;
   logic [CNT_W-1:0] period_n;
   logic [CNT_W:0]   sample;
   logic [CNT_W-1:0] sample_q;
   logic             rise;
   logic             qualified;
   logic             at_timeout;
   logic             match_cand;
   logic             match_period;
   logic             enter_lock;

   // Absolute difference of two extended-width values compared against TOL.
   function automatic logic within_tol(input logic [CNT_W:0] a,
                                       input logic [CNT_W:0] b);
      logic [CNT_W:0] diff;
      diff = (a >= b) ? (a - b) : (b - a);
      return (diff <= TOL_C);
   endfunction

   // Two-flop synchronizer for the asynchronous tone line plus a history flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= tone_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise       = s2 & ~s3;
   assign sample     = {1'b0, cnt} + (CNT_W+1)'(1);
   assign sample_q   = sample[CNT_W] ? {CNT_W{1'b1}} : sample[CNT_W-1:0];
   assign at_timeout = (cnt == TIMEOUT_C);
   assign qualified  = rise && ((state == IDLE) || (sample >= MIN_C));
   assign match_cand   = within_tol(sample, {1'b0, cand});
   assign match_period = within_tol(sample, {1'b0, period});

   // Cycles since the last qualified edge; saturates so silence stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (qualified) begin
         cnt <= '0;
      end else if (!at_timeout) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Next-state logic: qualified edges drive measurement, timeout falls back to IDLE.
   always_comb begin
      state_n    = state;
      cand_n     = cand;
      period_n   = period;
      enter_lock = 1'b0;
      case (state)
         IDLE: begin
            if (qualified) begin
               state_n = ARM;
            end
         end
         ARM: begin
            if (qualified) begin
               cand_n  = sample_q;
               state_n = MEASURE;
            end else if (at_timeout) begin
               cand_n  = '0;
               state_n = IDLE;
            end
         end
         MEASURE: begin
            if (qualified) begin
               if (match_cand) begin
                  period_n   = sample_q;
                  enter_lock = 1'b1;
                  state_n    = LOCKED;
               end else begin
                  cand_n = sample_q;
               end
            end else if (at_timeout) begin
               cand_n  = '0;
               state_n = IDLE;
            end
         end
         LOCKED: begin
            if (qualified) begin
               if (!match_period) begin
                  cand_n  = sample_q;
                  state_n = MEASURE;
               end
            end else if (at_timeout) begin
               cand_n  = '0;
               state_n = IDLE;
            end
         end
         default: begin
            cand_n  = '0;
            state_n = IDLE;
         end
      endcase
   end

   // State, candidate and registered outputs all update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cand         <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         tone_new     <= 1'b0;
         silent       <= 1'b1;
      end else begin
         state        <= state_n;
         cand         <= cand_n;
         period       <= period_n;
         period_valid <= (state_n == LOCKED);
         tone_new     <= enter_lock;
         silent       <= (state_n == IDLE);
      end
   end

endmodule
